// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for a FIFO register file that accepts
// one operation per clock. Arbitrates push/pop collisions with a toggling priority.
module fifo_ctrl #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic         rd,
   output logic         wr_ack,
   output logic         rd_ack,
   output logic         wr_en,
   output logic         re_en,
   output logic [W-1:0] w_addr,
   output logic [W-1:0] r_addr,
   output logic         full,
   output logic         empty,
   output logic [W:0]   level,
   output logic         rd_valid
);

   localparam int unsigned DEPTH = 1 << W;
   localparam int unsigned CW    = W + 1;

   logic [W-1:0] w_ptr;
   logic [W-1:0] r_ptr;
   logic [W:0]   count;
   logic         prio;
   logic         rd_valid_q;

   logic         push_ok;
   logic         pop_ok;
   logic         conflict;
   logic         w_grant;
   logic         r_grant;

   // Flags come from the registered count only; pointers are never compared.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == CW'(0));

   // Grant arbitration: a lone eligible request wins; a collision goes to prio.
   always_comb begin
      push_ok  = wr & ~full;
      pop_ok   = rd & ~empty;
      conflict = push_ok & pop_ok;
      w_grant  = 1'b0;
      r_grant  = 1'b0;
      if (!reset) begin
         if (conflict) begin
            w_grant = ~prio;
            r_grant = prio;
         end else begin
            w_grant = push_ok;
            r_grant = pop_ok;
         end
      end
   end

   // Pointer, occupancy, priority and read-valid state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr      <= '0;
         r_ptr      <= '0;
         count      <= '0;
         prio       <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         if (w_grant) begin
            w_ptr <= w_ptr + 1'b1;
         end
         if (r_grant) begin
            r_ptr <= r_ptr + 1'b1;
         end
         case ({w_grant, r_grant})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (conflict) begin
            prio <= ~prio;
         end
         rd_valid_q <= r_grant;
      end
   end

   assign wr_en    = w_grant;
   assign re_en    = r_grant;
   assign wr_ack   = w_grant;
   assign rd_ack   = r_grant;
   assign w_addr   = w_ptr;
   assign r_addr   = r_ptr;
   assign level    = count;
   assign rd_valid = rd_valid_q;

   // The storage array can only take one operation per cycle.
   one_op_per_cycle: assert property (@(posedge clk) disable iff (reset) !(wr_en && re_en));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed scenarios with a data scoreboard through a storage model.
module tb_fifo_ctrl;

   localparam int unsigned W     = 2;
   localparam int unsigned DEPTH = 1 << W;

   logic         clk;
   logic         reset;
   logic         wr;
   logic         rd;
   logic         wr_ack;
   logic         rd_ack;
   logic         wr_en;
   logic         re_en;
   logic [W-1:0] w_addr;
   logic [W-1:0] r_addr;
   logic         full;
   logic         empty;
   logic [W:0]   level;
   logic         rd_valid;

   logic [7:0]   w_data;
   logic [7:0]   r_data;
   logic [7:0]   mem [DEPTH];
   logic [7:0]   sb [$];

   int n_checks;
   int n_fail;

   fifo_ctrl #(.W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       (rd),
      .wr_ack   (wr_ack),
      .rd_ack   (rd_ack),
      .wr_en    (wr_en),
      .re_en    (re_en),
      .w_addr   (w_addr),
      .r_addr   (r_addr),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .rd_valid (rd_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Storage register file: write wins, registered read data.
   always @(posedge clk) begin
      if (wr_en) mem[w_addr] <= w_data;
      else if (re_en) r_data <= mem[r_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Inputs are changed at posedge+1; settle lands before the falling edge.
   task automatic settle();
      #2;
   endtask

   // Clock edge with scoreboard push on write grant and pop on rd_valid.
   task automatic tick();
      logic [7:0] exp;
      n_checks++;
      if (wr_en && re_en) begin
         n_fail++;
         $display("FAIL both_enables: wr_en=%0b re_en=%0b required not both 1", wr_en, re_en);
      end
      if (wr_ack) sb.push_back(w_data);
      @(posedge clk);
      #1;
      if (rd_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: rd_valid=1 with no outstanding write");
         end else begin
            exp = sb.pop_front();
            if (r_data !== exp) begin
               n_fail++;
               $display("FAIL sb_data: r_data=%0h expected %0h", r_data, exp);
            end
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr    = 1'b0;
      rd    = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wr    = 1'b1;
      rd    = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: level=%0d empty=%0b full=%0b rd_valid=%0b required 0 1 0 0",
                  level, empty, full, rd_valid);
      end
      n_checks++;
      if (wr_en !== 1'b0 || re_en !== 1'b0 || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_enables: wr_en=%0b re_en=%0b wr_ack=%0b rd_ack=%0b required all 0",
                  wr_en, re_en, wr_ack, rd_ack);
      end
      n_checks++;
      if (w_addr !== 2'd0 || r_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_addr: w_addr=%0d r_addr=%0d required 0 0", w_addr, r_addr);
      end
      wr = 1'b0;
      rd = 1'b0;
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      bit [4:0] exp_ack = 5'b01111;
      do_reset();
      wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         w_data = 8'($urandom);
         settle();
         n_checks++;
         if (wr_ack !== exp_ack[i] || w_addr !== 2'(i % 4)) begin
            n_fail++;
            $display("FAIL fill_grant[%0d]: wr_ack=%0b w_addr=%0d required %0b %0d",
                     i, wr_ack, w_addr, exp_ack[i], i % 4);
         end
         tick();
         n_checks++;
         if (level !== 3'((i < 4) ? i + 1 : 4) || full !== 1'(i >= 3)) begin
            n_fail++;
            $display("FAIL fill_level[%0d]: level=%0d full=%0b required %0d %0b",
                     i, level, full, (i < 4) ? i + 1 : 4, i >= 3);
         end
      end
      wr = 1'b0;
   endtask

   task automatic test_empty_read();
      do_reset();
      rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_checks++;
         if (re_en !== 1'b0 || rd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rd_grant[%0d]: re_en=%0b rd_ack=%0b required 0 0", i, re_en, rd_ack);
         end
         tick();
         n_checks++;
         if (rd_valid !== 1'b0 || level !== 3'd0 || r_addr !== 2'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_rd_state[%0d]: rd_valid=%0b level=%0d r_addr=%0d empty=%0b required 0 0 0 1",
                     i, rd_valid, level, r_addr, empty);
         end
      end
      rd = 1'b0;
   endtask

   task automatic test_conflict();
      bit [3:0] exp_w   = 4'b0101;
      int       exp_l[4] = '{3, 2, 3, 2};
      do_reset();
      wr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         w_data = 8'($urandom);
         settle();
         tick();
      end
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w_data = 8'($urandom);
         settle();
         n_checks++;
         if (wr_ack !== exp_w[i] || rd_ack !== ~exp_w[i]) begin
            n_fail++;
            $display("FAIL conflict_grant[%0d]: wr_ack=%0b rd_ack=%0b required %0b %0b",
                     i, wr_ack, rd_ack, exp_w[i], ~exp_w[i]);
         end
         tick();
         n_checks++;
         if (level !== 3'(exp_l[i])) begin
            n_fail++;
            $display("FAIL conflict_level[%0d]: level=%0d required %0d", i, level, exp_l[i]);
         end
      end
      rd = 1'b0;
   endtask

   // Continues from the level-2, prio-0 state left by test_conflict.
   task automatic test_full_conflict();
      wr = 1'b1;
      rd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w_data = 8'($urandom);
         settle();
         tick();
      end
      n_checks++;
      if (full !== 1'b1 || level !== 3'd4) begin
         n_fail++;
         $display("FAIL full_setup: full=%0b level=%0d required 1 4", full, level);
      end
      rd     = 1'b1;
      w_data = 8'($urandom);
      settle();
      n_checks++;
      if (wr_ack !== 1'b0 || rd_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL full_conflict_grant: wr_ack=%0b rd_ack=%0b required 0 1", wr_ack, rd_ack);
      end
      tick();
      n_checks++;
      if (level !== 3'd3) begin
         n_fail++;
         $display("FAIL full_conflict_level: level=%0d required 3", level);
      end
      settle();
      n_checks++;
      if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL after_full_grant: wr_ack=%0b rd_ack=%0b required 1 0", wr_ack, rd_ack);
      end
      tick();
      n_checks++;
      if (level !== 3'd4) begin
         n_fail++;
         $display("FAIL after_full_level: level=%0d required 4", level);
      end
      wr = 1'b0;
      rd = 1'b0;
      settle();
      tick();
   endtask

   task automatic test_read_data();
      logic [7:0] exp_d[2] = '{8'hA1, 8'hB2};
      do_reset();
      wr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         w_data = exp_d[i];
         settle();
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         tick();
         n_checks++;
         if (rd_valid !== 1'b1 || r_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL read_data[%0d]: rd_valid=%0b r_data=%0h required 1 %0h",
                     i, rd_valid, r_data, exp_d[i]);
         end
      end
      rd = 1'b0;
      settle();
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || r_data !== 8'hB2 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL read_hold: rd_valid=%0b r_data=%0h empty=%0b required 0 b2 1",
                  rd_valid, r_data, empty);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w_data = 8'($urandom);
         settle();
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      settle();
      tick();
      n_checks++;
      if (level !== 3'd3 || rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_setup: level=%0d rd_valid=%0b required 3 1", level, rd_valid);
      end
      wr = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (level !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || wr_en !== 1'b0 || re_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: level=%0d empty=%0b rd_valid=%0b wr_en=%0b re_en=%0b required 0 1 0 0 0",
                  level, empty, rd_valid, wr_en, re_en);
      end
      reset = 1'b0;
      rd    = 1'b0;
      sb.delete();
      w_data = 8'h5C;
      #1;
      n_checks++;
      if (wr_ack !== 1'b1 || w_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL post_reset_push: wr_ack=%0b w_addr=%0d required 1 0", wr_ack, w_addr);
      end
      tick();
      n_checks++;
      if (level !== 3'd1) begin
         n_fail++;
         $display("FAIL post_reset_level: level=%0d required 1", level);
      end
      wr = 1'b0;
      rd = 1'b1;
      settle();
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || r_data !== 8'h5C) begin
         n_fail++;
         $display("FAIL post_reset_read: rd_valid=%0b r_data=%0h required 1 5c", rd_valid, r_data);
      end
      rd = 1'b0;
      settle();
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      wr       = 1'b0;
      rd       = 1'b0;
      w_data   = 8'h00;
      test_reset();
      test_fill();
      test_empty_read();
      test_conflict();
      test_full_conflict();
      test_read_data();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
